// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - word-aligned load/store bus adapter with core stall and fault reporting
// Optional bus timeout abort: define LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_next;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, word_q;
  logic [1:0]  cause_q;
  logic        illegal, misaligned, timeout_hit;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  // Illegal encodings win over misalignment when both apply.
  always_comb begin
    illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
              (req_we && req_funct3[2]);
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tcnt;

  // Held at zero outside BUSY, so each BUSY entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (!reset || state != BUSY) tcnt <= '0;
    else if (!bus_ready)         tcnt <= tcnt + 1'b1;
  end

  assign timeout_hit = (state == BUSY) && !bus_ready && (tcnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      cause_q <= 2'b00;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        word_q  <= '0;
        cause_q <= illegal ? 2'b10 : (misaligned ? 2'b01 : 2'b00);
      end else if (state == BUSY) begin
        if (bus_ready)        word_q  <= we_q ? 32'h0 : bus_rdata;
        else if (timeout_hit) cause_q <= 2'b11;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = (illegal || misaligned) ? RESP : BUSY;
      BUSY: if (bus_ready || timeout_hit) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   lane_byte = word_q[7:0];
      2'b01:   lane_byte = word_q[15:8];
      2'b10:   lane_byte = word_q[23:16];
      default: lane_byte = word_q[31:24];
    endcase
    lane_half = addr_q[1] ? word_q[31:16] : word_q[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_ext = {24'h0, lane_byte};
      3'b101:  load_ext = {16'h0, lane_half};
      default: load_ext = word_q;
    endcase
  end

  always_comb begin
    stall       = reset && ((state == IDLE && req_valid) || state == BUSY);
    done        = (state == RESP);
    fault       = done && (cause_q != 2'b00);
    fault_cause = done ? cause_q : 2'b00;
    rdata       = (done && !fault && !we_q) ? load_ext : 32'h0;
    bus_valid   = (state == BUSY);
    bus_we      = bus_valid && we_q;
    bus_addr    = {addr_q[31:2], 2'b00};
    bus_wstrb   = 4'b0000;
    bus_wdata   = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        bus_wdata = {4{wdata_q[7:0]}};
        if (bus_we) bus_wstrb = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        bus_wdata = {2{wdata_q[15:0]}};
        if (bus_we) bus_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: if (bus_we) bus_wstrb = 4'b1111;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
// Timeout scenario follows LSU_TIMEOUT_EN when defined.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, fault;
  logic [31:0] rdata;
  logic [1:0]  fault_cause;
  logic        bus_valid, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .done(done), .rdata(rdata),
    .fault(fault), .fault_cause(fault_cause), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    issue(1'b0, 3'b010, 32'h0, 32'h0);
    #1;
    n_checks++;
    if ({stall, done, fault, bus_valid, fault_cause, rdata} !== 37'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got stall=%b done=%b fault=%b bus_valid=%b cause=%b rdata=%h, required all 0",
               stall, done, fault, bus_valid, fault_cause, rdata);
    end
    req_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_load_byte();
    issue(1'b0, 3'b000, 32'h103, 32'h0);
    #1;
    n_checks++;
    if ({stall, bus_valid, done} !== 3'b100) begin
      n_fail++; $display("FAIL lb_accept: got stall,bus_valid,done=%b required 100", {stall, bus_valid, done});
    end
    step();
    req_valid = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h80FF_1234;
    #1;
    n_checks++;
    if ({bus_valid, bus_we, stall, bus_wstrb, bus_addr} !== {3'b101, 4'b0000, 32'h100}) begin
      n_fail++; $display("FAIL lb_bus: got valid,we,stall=%b wstrb=%b addr=%h required 101 0000 00000100",
                         {bus_valid, bus_we, stall}, bus_wstrb, bus_addr);
    end
    step();
    bus_ready = 1'b0;
    n_checks++;
    if ({done, fault, stall, bus_valid, rdata} !== {4'b1000, 32'hFFFF_FF80}) begin
      n_fail++; $display("FAIL lb_resp: got done,fault,stall,bus_valid=%b rdata=%h required 1000 ffffff80",
                         {done, fault, stall, bus_valid}, rdata);
    end
    step();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL lb_done_pulse: got done=%b required 0", done);
    end
  endtask

  task automatic test_load_half_wait();
    int stalls = 0;
    issue(1'b0, 3'b101, 32'h202, 32'h0);
    #1;
    stalls += int'(stall);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({bus_valid, bus_addr, done} !== {1'b1, 32'h200, 1'b0}) begin
        n_fail++; $display("FAIL lhu_wait%0d: got bus_valid=%b addr=%h done=%b required 1 00000200 0",
                           i, bus_valid, bus_addr, done);
      end
      stalls += int'(stall);
      step();
    end
    bus_ready = 1'b1; bus_rdata = 32'hBEEF_0000;
    #1;
    stalls += int'(stall);
    step();
    bus_ready = 1'b0;
    n_checks++;
    if (stalls !== 5) begin
      n_fail++; $display("FAIL lhu_stall_cycles: got %0d required 5", stalls);
    end
    n_checks++;
    if ({done, fault, rdata} !== {2'b10, 32'h0000_BEEF}) begin
      n_fail++; $display("FAIL lhu_resp: got done,fault=%b rdata=%h required 10 0000beef", {done, fault}, rdata);
    end
    step();
  endtask

  task automatic test_stores();
    logic [2:0]  f3[3]  = '{3'b000, 3'b001, 3'b010};
    logic [31:0] ad[3]  = '{32'h31, 32'h42, 32'h8};
    logic [31:0] wd[3]  = '{32'h0000_00AB, 32'h5678_1234, 32'hDEAD_BEEF};
    logic [3:0]  es[3]  = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] ed[3]  = '{32'hABAB_ABAB, 32'h1234_1234, 32'hDEAD_BEEF};
    logic [31:0] ea[3]  = '{32'h30, 32'h40, 32'h8};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, f3[i], ad[i], wd[i]);
      step();
      req_valid = 1'b0;
      #1;
      n_checks++;
      if ({bus_valid, bus_we, bus_wstrb, bus_wdata, bus_addr} !== {2'b11, es[i], ed[i], ea[i]}) begin
        n_fail++; $display("FAIL store%0d_bus: got valid,we=%b wstrb=%b wdata=%h addr=%h required 11 %b %h %h",
                           i, {bus_valid, bus_we}, bus_wstrb, bus_wdata, bus_addr, es[i], ed[i], ea[i]);
      end
      bus_ready = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      step();
      bus_ready = 1'b0;
      n_checks++;
      if ({done, fault, rdata} !== {2'b10, 32'h0}) begin
        n_fail++; $display("FAIL store%0d_resp: got done,fault=%b rdata=%h required 10 00000000", i, {done, fault}, rdata);
      end
      step();
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3[4] = '{3'b001, 3'b100, 3'b010, 3'b000};
    logic [31:0] ad[4] = '{32'h0, 32'h2, 32'h4, 32'h11};
    logic [31:0] wo[4] = '{32'h0000_8001, 32'h00C3_0000, 32'h1234_5678, 32'h0000_7F00};
    logic [31:0] ex[4] = '{32'hFFFF_8001, 32'h0000_00C3, 32'h1234_5678, 32'h0000_007F};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, f3[i], ad[i], 32'h0);
      step();
      req_valid = 1'b0; bus_ready = 1'b1; bus_rdata = wo[i];
      step();
      bus_ready = 1'b0;
      n_checks++;
      if ({done, fault, rdata} !== {2'b10, ex[i]}) begin
        n_fail++; $display("FAIL load%0d_extend: got done,fault=%b rdata=%h required 10 %h", i, {done, fault}, rdata, ex[i]);
      end
      step();
    end
  endtask

  task automatic test_faults();
    logic        we[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3[5] = '{3'b010, 3'b011, 3'b100, 3'b111, 3'b001};
    logic [31:0] ad[5] = '{32'h6, 32'h0, 32'h0, 32'h1, 32'h43};
    logic [1:0]  ec[5] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
    bus_ready = 1'b1; bus_rdata = 32'h5555_5555;
    for (int i = 0; i < 5; i++) begin
      issue(we[i], f3[i], ad[i], 32'hFFFF_FFFF);
      #1;
      n_checks++;
      if ({stall, bus_valid} !== 2'b10) begin
        n_fail++; $display("FAIL fault%0d_accept: got stall,bus_valid=%b required 10", i, {stall, bus_valid});
      end
      step();
      req_valid = 1'b0;
      n_checks++;
      if ({done, fault, fault_cause, bus_valid, stall, rdata} !== {2'b11, ec[i], 2'b00, 32'h0}) begin
        n_fail++; $display("FAIL fault%0d_resp: got done,fault=%b cause=%b valid,stall=%b rdata=%h required 11 %b 00 00000000",
                           i, {done, fault}, fault_cause, {bus_valid, stall}, rdata, ec[i]);
      end
      step();
    end
    bus_ready = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    step();
    req_valid = 1'b0;
    n_checks++;
    if (bus_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_busy_entry: got bus_valid=%b required 1", bus_valid);
    end
    reset = 1'b0;
    step();
    reset = 1'b1; bus_ready = 1'b1;
    #1;
    n_checks++;
    if ({bus_valid, done, stall} !== 3'b000) begin
      n_fail++; $display("FAIL rst_abort: got bus_valid,done,stall=%b required 000", {bus_valid, done, stall});
    end
    step();
    n_checks++;
    if ({bus_valid, done} !== 2'b00) begin
      n_fail++; $display("FAIL rst_no_done: got bus_valid,done=%b required 00", {bus_valid, done});
    end
    bus_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    step();
    req_valid = 1'b0; bus_ready = 1'b1; bus_rdata = 32'hCAFE_F00D;
    step();
    bus_ready = 1'b0;
    n_checks++;
    if ({done, fault, rdata} !== {2'b10, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL rst_next_lw: got done,fault=%b rdata=%h required 10 cafef00d", {done, fault}, rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    step();
    req_valid = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h1122_3344;
    step();
    bus_ready = 1'b0;
    issue(1'b0, 3'b100, 32'h41, 32'h0);
    #1;
    n_checks++;
    if ({done, stall, rdata} !== {2'b10, 32'h1122_3344}) begin
      n_fail++; $display("FAIL b2b_first: got done,stall=%b rdata=%h required 10 11223344", {done, stall}, rdata);
    end
    step();
    n_checks++;
    if ({stall, bus_valid, done} !== 3'b100) begin
      n_fail++; $display("FAIL b2b_second_accept: got stall,bus_valid,done=%b required 100", {stall, bus_valid, done});
    end
    step();
    req_valid = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h0000_AA00;
    #1;
    n_checks++;
    if ({bus_valid, bus_addr} !== {1'b1, 32'h40}) begin
      n_fail++; $display("FAIL b2b_second_bus: got bus_valid=%b addr=%h required 1 00000040", bus_valid, bus_addr);
    end
    step();
    bus_ready = 1'b0;
    n_checks++;
    if ({done, rdata} !== {1'b1, 32'h0000_00AA}) begin
      n_fail++; $display("FAIL b2b_second_resp: got done=%b rdata=%h required 1 000000aa", done, rdata);
    end
    step();
  endtask

  task automatic test_timeout();
    issue(1'b0, 3'b010, 32'h50, 32'h0);
    step();
    req_valid = 1'b0;
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({bus_valid, stall, done} !== 3'b110) begin
        n_fail++; $display("FAIL to_busy%0d: got valid,stall,done=%b required 110", i, {bus_valid, stall, done});
      end
      step();
    end
    n_checks++;
    if ({done, fault, fault_cause, bus_valid, rdata} !== {4'b1111, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL to_abort: got done,fault=%b cause=%b valid=%b rdata=%h required 11 11 0 00000000",
                         {done, fault}, fault_cause, bus_valid, rdata);
    end
    step();
    issue(1'b0, 3'b010, 32'h54, 32'h0);
    step();
    req_valid = 1'b0;
    step(); step(); step();
    bus_ready = 1'b1; bus_rdata = 32'h0BAD_F00D;
    step();
    bus_ready = 1'b0;
    n_checks++;
    if ({done, fault, fault_cause, rdata} !== {4'b1000, 32'h0BAD_F00D}) begin
      n_fail++; $display("FAIL to_ready_wins: got done,fault=%b cause=%b rdata=%h required 10 00 0badf00d",
                         {done, fault}, fault_cause, rdata);
    end
`else
    for (int i = 0; i < 40; i++) begin
      n_checks++;
      if ({bus_valid, stall, done} !== 3'b110) begin
        n_fail++; $display("FAIL hold%0d: got valid,stall,done=%b required 110", i, {bus_valid, stall, done});
      end
      step();
    end
    bus_ready = 1'b1; bus_rdata = 32'h0BAD_F00D;
    step();
    bus_ready = 1'b0;
    n_checks++;
    if ({done, fault, fault_cause, rdata} !== {4'b1000, 32'h0BAD_F00D}) begin
      n_fail++; $display("FAIL hold_release: got done,fault=%b cause=%b rdata=%h required 10 00 0badf00d",
                         {done, fault}, fault_cause, rdata);
    end
`endif
    step();
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
    step();
    test_reset();
    test_load_byte();
    test_load_half_wait();
    test_stores();
    test_load_extend();
    test_faults();
    test_reset_mid_busy();
    test_back_to_back();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
